// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the memory stage: funct3 load/store widths,
// write-back source selects and the memory-access FSM state type.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access width is carried in funct3[1:0]; funct3[2] selects zero extension.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the byte/half addressed by addr[1:0] out of the
// returned word and sign- or zero-extends it according to funct3.
module mem_load_align
  import rv32i_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic uns);
    logic signed [7:0]  s;
    logic signed [31:0] w;
    s = b;
    w = s;
    return uns ? {24'b0, b} : w;
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic uns);
    logic signed [15:0] s;
    logic signed [31:0] w;
    s = h;
    w = s;
    return uns ? {16'b0, h} : w;
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension for the addressed sub-word.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i[1:0])
      SZ_B:    data_o = ext8(byte_sel, funct3_i[2]);
      SZ_H:    data_o = ext16(half_sel, funct3_i[2]);
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage. Issues loads/stores on a single-outstanding req/ready
// data-memory port, stalls upstream while an access is pending and registers
// the MEM/WB fields consumed by wb_stage.
// Optional feature: define DMEM_TIMEOUT_EN to abort an access that waits
// TIMEOUT_CYCLES cycles without ready (reported on bus_err_o).
module mem_stage
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic        regwrite_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [31:0] pc_address_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_o,
  output logic        regwrite_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] data_mem_o,
  output logic [31:0] pc_address_o,
  output logic [1:0]  wb_sel_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      SZ_B:    return 1'b0;
      SZ_H:    return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  mem_state_e  state_q;
  logic        mem_op;
  logic        misal;
  logic        start;
  logic        expire;
  logic [31:0] ld_data;

  // Command captured at issue; upstream holds EX/MEM, but these keep the
  // completion path independent of what the pipeline presents meanwhile.
  logic [2:0]  funct3_p0;
  logic [1:0]  addr_lo_p0;
  logic        regwrite_p0;
  logic [4:0]  rd_p0;
  logic [31:0] alu_p0;
  logic [31:0] pc_p0;
  logic [1:0]  wb_sel_p0;

  assign mem_op  = mem_read_i | mem_write_i;
  assign misal   = mem_op & is_misaligned(funct3_i, alu_result_i[1:0]);
  assign start   = (state_q == MEM_IDLE) & valid_i & mem_op & ~misal;
  assign stall_o = start | ((state_q == MEM_WAIT) & ~dmem_ready_i & ~expire);

  mem_load_align u_align (
    .addr_lo_i (addr_lo_p0),
    .funct3_i  (funct3_p0),
    .rdata_i   (dmem_rdata_i),
    .data_o    (ld_data)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             bus_err_q;

  assign expire = (state_q == MEM_WAIT) & ~dmem_ready_i &
                  (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter; cleared whenever the access is not stuck waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else if (state_q == MEM_WAIT && !dmem_ready_i && !expire) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  // Abort flag for the MEM/WB entry produced by an expired access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= expire;
    end
  end

  assign bus_err_o = bus_err_q;
`else
  assign expire    = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  // ---- EX/MEM -> memory request ----
  // Access FSM and the registered data-memory request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= MEM_IDLE;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (start) begin
            state_q      <= MEM_WAIT;
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= mem_write_i;
            dmem_addr_o  <= {alu_result_i[31:2], 2'b00};
            dmem_be_o    <= mem_write_i ? store_be(funct3_i, alu_result_i[1:0]) : 4'b1111;
            dmem_wdata_o <= mem_write_i ? store_wdata(funct3_i, rs2_data_i) : 32'h0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready_i || expire) begin
            state_q    <= MEM_IDLE;
            dmem_req_o <= 1'b0;
          end
        end
        default: begin
          state_q    <= MEM_IDLE;
          dmem_req_o <= 1'b0;
        end
      endcase
    end
  end

  // Capture the fields needed to complete the pending access.
  always_ff @(posedge clk_i) begin
    if (start) begin
      funct3_p0   <= funct3_i;
      addr_lo_p0  <= alu_result_i[1:0];
      regwrite_p0 <= regwrite_i;
      rd_p0       <= rd_addr_i;
      alu_p0      <= alu_result_i;
      pc_p0       <= pc_address_i;
      wb_sel_p0   <= wb_sel_i;
    end
  end

  // ---- memory -> MEM/WB ----
  // MEM/WB register: pass-through, bubble, completion or abort entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o      <= 1'b0;
      regwrite_o   <= 1'b0;
      rd_addr_o    <= '0;
      alu_result_o <= '0;
      data_mem_o   <= '0;
      pc_address_o <= '0;
      wb_sel_o     <= '0;
      misalign_o   <= 1'b0;
    end else if (state_q == MEM_IDLE) begin
      valid_o      <= valid_i & ~start;
      regwrite_o   <= valid_i & regwrite_i & ~start & ~misal;
      rd_addr_o    <= rd_addr_i;
      alu_result_o <= alu_result_i;
      data_mem_o   <= '0;
      pc_address_o <= pc_address_i;
      wb_sel_o     <= wb_sel_i;
      misalign_o   <= valid_i & misal;
    end else if (dmem_ready_i || expire) begin
      valid_o      <= 1'b1;
      regwrite_o   <= regwrite_p0 & ~expire;
      rd_addr_o    <= rd_p0;
      alu_result_o <= alu_p0;
      data_mem_o   <= (dmem_we_o || expire) ? 32'h0 : ld_data;
      pc_address_o <= pc_p0;
      wb_sel_o     <= wb_sel_p0;
      misalign_o   <= 1'b0;
    end else begin
      valid_o      <= 1'b0;
      regwrite_o   <= 1'b0;
      misalign_o   <= 1'b0;
    end
  end

endmodule
